// File: rtl/fsmc_pkg.sv
// Shared FSMC definitions: bus-cycle state encoding, counter widths and default
// timing; also imported by the clocked_bus_slave benches.
package fsmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } fsmc_state_t;

  localparam int CNT_W  = 6;   // wide enough for DATAST up to 63
  localparam int IDLE_W = 5;   // wide enough for IDLE_MIN + turnaround (17)

  localparam int DEF_ADDSET   = 2;
  localparam int DEF_DATAST   = 8;
  localparam int DEF_HOLD     = 2;
  localparam int DEF_IDLE_MIN = 3;

  // Down-counter reload value for a phase lasting 'cycles' clocks.
  function automatic logic [CNT_W-1:0] phase_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/fsmc_bus_master.sv
// FSMC-style asynchronous bus master: IDLE/SETUP/STROBE/HOLD with registered pins.
// Optional macro FSMC_MASTER_TURNAROUND_EN adds 2 idle cycles between a read and a following write.
module fsmc_bus_master
  import fsmc_pkg::*;
#(
  parameter int ADRW     = 8,
  parameter int DATW     = 16,
  parameter int ADDSET   = DEF_ADDSET,
  parameter int DATAST   = DEF_DATAST,
  parameter int HOLD     = DEF_HOLD,
  parameter int IDLE_MIN = DEF_IDLE_MIN
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [ADRW-1:0] req_adr,
  input  logic [DATW-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [DATW-1:0] rsp_rdata,
  output logic            aNE,
  output logic            aNOE,
  output logic            aNWE,
  output logic [ADRW-1:0] aAn,
  output logic            io_output,
  output logic [DATW-1:0] io_data,
  input  logic [DATW-1:0] aDn
);

  localparam logic [CNT_W-1:0]  LOAD_SETUP  = phase_load(ADDSET);
  localparam logic [CNT_W-1:0]  LOAD_STROBE = phase_load(DATAST);
  localparam logic [CNT_W-1:0]  LOAD_HOLD   = phase_load(HOLD);
  localparam logic [IDLE_W-1:0] IDLE_REQ    = IDLE_W'(IDLE_MIN);

  fsmc_state_t       state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [IDLE_W-1:0] idle_cnt, idle_next;
  logic              we_r, we_next, accept, ready_r;
  logic              ne_d, noe_d, nwe_d, io_output_d, rsp_valid_d, ready_d, capture;

  assign accept = req_valid & req_ready;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idle_cnt <= '0;
      we_r     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state    <= state_next;
      cnt      <= cnt_next;
      idle_cnt <= idle_next;
      if (accept) we_r <= req_we;
    end
  end

  // Next-state and counter logic
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      ST_IDLE: if (accept) begin
        state_next = ST_SETUP;
        cnt_next   = LOAD_SETUP;
      end
      ST_SETUP: if (cnt == '0) begin
        state_next = ST_STROBE;
        cnt_next   = LOAD_STROBE;
      end else cnt_next = cnt - 1'b1;
      ST_STROBE: if (cnt == '0) begin
        state_next = ST_HOLD;
        cnt_next   = LOAD_HOLD;
      end else cnt_next = cnt - 1'b1;
      ST_HOLD: if (cnt == '0) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else cnt_next = cnt - 1'b1;
      default: state_next = ST_IDLE;
    endcase

    // idle_cnt = consecutive NE-high cycles including the current one
    if (state_next != ST_IDLE)  idle_next = '0;
    else if (idle_cnt == '1)    idle_next = idle_cnt;
    else                        idle_next = idle_cnt + 1'b1;
  end

  // Output logic: pin values are derived from the next state and registered,
  // so every pin changes exactly on the edge that changes the state.
  always_comb begin
    we_next     = accept ? req_we : we_r;
    ne_d        = (state_next == ST_IDLE);
    noe_d       = !((state_next == ST_STROBE) && !we_next);
    nwe_d       = !((state_next == ST_STROBE) && we_next);
    io_output_d = (state_next != ST_IDLE) && we_next;
    rsp_valid_d = (state == ST_STROBE) && (state_next == ST_HOLD);
    capture     = (state == ST_STROBE) && (cnt == '0) && !we_r;
    ready_d     = (state_next == ST_IDLE) && (idle_next >= IDLE_REQ);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      aNE       <= 1'b1;
      aNOE      <= 1'b1;
      aNWE      <= 1'b1;
      io_output <= 1'b0;
      aAn       <= '0;
      io_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ready_r   <= 1'b0;
    end else begin
      aNE       <= ne_d;
      aNOE      <= noe_d;
      aNWE      <= nwe_d;
      io_output <= io_output_d;
      rsp_valid <= rsp_valid_d;
      ready_r   <= ready_d;
      if (capture) rsp_rdata <= aDn;
      if (accept) begin
        aAn     <= req_adr;
        io_data <= req_we ? req_wdata : '0;
      end else if (state_next == ST_IDLE) begin
        io_data <= '0;
      end
    end
  end

`ifdef FSMC_MASTER_TURNAROUND_EN
  localparam logic [IDLE_W-1:0] TA_REQ = IDLE_W'(IDLE_MIN + 2);
  logic last_rd, ta_block;

  // After a read, writes are held off until the pad has had two extra idle cycles.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_rd  <= 1'b0;
      ta_block <= 1'b0;
    end else begin
      if (rsp_valid_d) last_rd <= !we_r;
      ta_block <= (rsp_valid_d ? !we_r : last_rd) && (idle_next < TA_REQ);
    end
  end

  assign req_ready = ready_r & ~(ta_block & req_we);
`else
  assign req_ready = ready_r;
`endif

endmodule

// File: tb/tb_fsmc_bus_master.sv
// Self-checking bench for fsmc_bus_master: directed requests, a response
// scoreboard, and a per-transaction bus-timing monitor.
module tb_fsmc_bus_master;

`ifdef FSMC_MASTER_TURNAROUND_EN
  localparam int RW_GAP = 5;
`else
  localparam int RW_GAP = 3;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_adr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        aNE, aNOE, aNWE, io_output;
  logic [7:0]  aAn;
  logic [15:0] io_data, aDn, rd_val;

  always #5 clk = ~clk;

  // Pad model: the slave drives rd_val only while output-enable is asserted.
  assign aDn = aNOE ? 16'h0000 : rd_val;

  fsmc_bus_master dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE), .aAn(aAn),
    .io_output(io_output), .io_data(io_data), .aDn(aDn)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          ne, nwe, noe, ioo, both_low, rsp_n, rsp_off, gap;
    logic [7:0]  adr;
    logic [15:0] wdata;
    bit          adr_stable;
  } stat_t;

  logic [15:0] exp_q[$];
  stat_t       stats_q[$];
  logic [15:0] model_rdata;

  // Bus monitor: one stat record per NE-low window, plus response scoreboard.
  stat_t       cur;
  bit          in_txn = 1'b0, gap_valid = 1'b0;
  int          high_run = 0, rsp_cnt = 0;
  logic [15:0] mon_e;

  always @(negedge clk) begin
    if (!nrst) begin
      in_txn = 1'b0; high_run = 0; gap_valid = 1'b0;
    end else if (!aNE) begin
      if (!in_txn) begin
        cur = '{default: 0};
        cur.gap = gap_valid ? high_run : -1;
        cur.adr = aAn; cur.wdata = io_data; cur.adr_stable = 1'b1; cur.rsp_off = -1;
        in_txn = 1'b1;
      end
      cur.ne++;
      if (!aNWE) cur.nwe++;
      if (!aNOE) cur.noe++;
      if (io_output) cur.ioo++;
      if (!aNOE && !aNWE) cur.both_low++;
      if (aAn !== cur.adr) cur.adr_stable = 1'b0;
      if (rsp_valid) begin
        cur.rsp_n++;
        if (cur.rsp_off < 0) cur.rsp_off = cur.ne - 1;
      end
      high_run = 0;
    end else begin
      if (in_txn) begin
        stats_q.push_back(cur);
        in_txn = 1'b0; gap_valid = 1'b1;
      end
      high_run++;
    end
    if (nrst && rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e);
      end
    end
  end

  // Loop-back slave: write to 0x00 loads chadr, write to 0x03 stores a char and advances it.
  int          do_write_cnt = 0;
  logic [15:0] chadr = 16'h0000;
  always @(posedge aNWE) begin
    if (nrst && !aNE) begin
      do_write_cnt++;
      if (aAn == 8'h00) chadr = io_data;
      else if (aAn == 8'h03) chadr = chadr + 16'h1;
    end
  end

  task automatic do_req(input logic we, input logic [7:0] adr, input logic [15:0] wdata);
    exp_q.push_back(we ? model_rdata : rd_val);
    if (!we) model_rdata = rd_val;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_adr = adr; req_wdata = wdata;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_stat(output stat_t s);
    s = '{default: 0};
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (stats_q.size() > 0) begin
        s = stats_q.pop_front();
        return;
      end
    end
    check("stat_timeout", 0, 1);
  endtask

  task automatic check_timing(input string tag, input stat_t s, input bit we, input logic [7:0] adr);
    check({tag, "_ne_low"}, s.ne, 12);
    check({tag, "_nwe_low"}, s.nwe, we ? 8 : 0);
    check({tag, "_noe_low"}, s.noe, we ? 0 : 8);
    check({tag, "_io_output"}, s.ioo, we ? 12 : 0);
    check({tag, "_rsp_off"}, s.rsp_off, 10);
    check({tag, "_rsp_n"}, s.rsp_n, 1);
    check({tag, "_both_low"}, s.both_low, 0);
    check({tag, "_adr"}, s.adr, adr);
    check({tag, "_adr_stable"}, s.adr_stable, 1);
  endtask

  initial begin
    stat_t s;
    int    n, w0, r0;
    nrst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_wdata = '0;
    rd_val = 16'h0000; model_rdata = 16'h0000;

    repeat (3) @(posedge clk); #1;
    check("rst_ne", aNE, 1);      check("rst_noe", aNOE, 1);   check("rst_nwe", aNWE, 1);
    check("rst_ioo", io_output, 0); check("rst_adr", aAn, 0);  check("rst_iodata", io_data, 0);
    check("rst_rspv", rsp_valid, 0); check("rst_rdata", rsp_rdata, 0); check("rst_ready", req_ready, 0);
    @(negedge clk); nrst = 1'b1;

    // Single write
    do_req(1'b1, 8'h02, 16'h0041);
    wait_stat(s);
    check_timing("wr", s, 1'b1, 8'h02);
    check("wr_wdata", s.wdata, 16'h0041);

    // Single read
    rd_val = 16'hBEEF;
    do_req(1'b0, 8'h05, 16'h0000);
    wait_stat(s);
    check_timing("rd", s, 1'b0, 8'h05);
    check("rd_gap", s.gap, 3);

    // req_valid held across three writes
    repeat (3) exp_q.push_back(model_rdata);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 8'h10; req_wdata = 16'h1111;
    n = 0;
    for (int i = 0; i < 300 && n < 3; i++) begin
      @(negedge clk);
      if (req_ready) n++;
    end
    @(posedge clk); #1; req_valid = 1'b0;
    check("held_accepts", n, 3);
    for (int k = 0; k < 3; k++) begin
      wait_stat(s);
      check_timing("held", s, 1'b1, 8'h10);
      check("held_gap", s.gap, (k == 0) ? RW_GAP : 3);
    end
    repeat (30) @(negedge clk);
    check("held_no_extra", stats_q.size(), 0);

    // Loop-back to a character-buffer slave
    w0 = do_write_cnt;
    do_req(1'b1, 8'h00, 16'h0020);
    do_req(1'b1, 8'h03, 16'h0041);
    wait_stat(s); wait_stat(s);
    check("lb_write_cnt", do_write_cnt - w0, 2);
    check("lb_chadr", chadr, 16'h0021);

    // Reset mid-STROBE of a write
    r0 = rsp_cnt;
    do_req(1'b1, 8'h0A, 16'hA5A5);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!aNWE) break;
    end
    repeat (2) @(negedge clk);
    #3 nrst = 1'b0;
    #1;
    check("abort_ne", aNE, 1);     check("abort_nwe", aNWE, 1);     check("abort_noe", aNOE, 1);
    check("abort_ioo", io_output, 0); check("abort_iodata", io_data, 0); check("abort_adr", aAn, 0);
    check("abort_rdata", rsp_rdata, 0); check("abort_ready", req_ready, 0);
    exp_q.delete();
    model_rdata = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk); nrst = 1'b1;
    check("abort_no_rsp", rsp_cnt, r0);
    check("abort_no_stat", stats_q.size(), 0);
    rd_val = 16'h1234;
    do_req(1'b0, 8'h07, 16'h0000);
    wait_stat(s);
    check_timing("post_rst_rd", s, 1'b0, 8'h07);

    // Read followed by write: turnaround spacing
    do_req(1'b1, 8'h09, 16'h5555);
    wait_stat(s);
    check_timing("ta_wr", s, 1'b1, 8'h09);
    check("ta_gap", s.gap, RW_GAP);

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
